// File: rtl/layer_ser_if.sv
// Handshake bundle for layer_serializer: parallel vector in, serial element stream out.
interface layer_ser_if #(
    parameter int NEURON_NUM = 30,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);
    logic [NEURON_NUM*DATA_WIDTH-1:0] in_data;
    logic                             in_valid;
    logic                             in_ready;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic                             out_last;
    logic [CNT_WIDTH-1:0]             out_index;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, out_index
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_index
    );
endinterface

// File: rtl/layer_serializer.sv
// Serializes a packed NEURON_NUM-element layer vector into one element per beat, element 0 first.
// Optional double buffering (back-to-back vectors without a bubble) is enabled by LAYER_SER_PINGPONG_EN.
module layer_serializer #(
    parameter int NEURON_NUM = 30,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    layer_ser_if.slave  bus,
    output logic        busy,
    output logic [7:0]  ovf_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NEURON_NUM - 1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   index_q, index_d;
    logic [DATA_WIDTH-1:0]  active_q [NEURON_NUM];
    logic [DATA_WIDTH-1:0]  active_d [NEURON_NUM];
    logic [7:0]             ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]  in_elem  [NEURON_NUM];
    logic [DATA_WIDTH-1:0]  out_data_c;
    logic                   in_ready_c;
    logic                   in_hs;
    logic                   out_hs;
    logic                   last_hs;

`ifdef LAYER_SER_PINGPONG_EN
    logic [DATA_WIDTH-1:0]  pend_q [NEURON_NUM];
    logic [DATA_WIDTH-1:0]  pend_d [NEURON_NUM];
    logic                   pend_full_q, pend_full_d;

    assign in_ready_c = !pend_full_q;
`else
    assign in_ready_c = (state_q == IDLE);
`endif

    generate
        for (genvar gi = 0; gi < NEURON_NUM; gi++) begin : g_unpack
            assign in_elem[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign in_hs   = bus.in_valid && in_ready_c;
    assign out_hs  = (state_q == SEND) && bus.out_ready;
    assign last_hs = out_hs && (index_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        active_d = active_q;
        ovf_d    = ovf_q;
`ifdef LAYER_SER_PINGPONG_EN
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
`endif
        // Dropped offers are only counted; they never touch the buffers.
        if (bus.in_valid && !in_ready_c && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    active_d = in_elem;
                    index_d  = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (last_hs) begin
`ifdef LAYER_SER_PINGPONG_EN
                    // Next vector comes from pending first, else straight from the input.
                    if (pend_full_q) begin
                        active_d    = pend_q;
                        index_d     = '0;
                        pend_full_d = 1'b0;
                    end else if (in_hs) begin
                        active_d = in_elem;
                        index_d  = '0;
                    end else begin
                        index_d = '0;
                        state_d = IDLE;
                    end
`else
                    index_d = '0;
                    state_d = IDLE;
`endif
                end else begin
                    if (out_hs) begin
                        index_d = index_q + 1'b1;
                    end
`ifdef LAYER_SER_PINGPONG_EN
                    if (in_hs) begin
                        pend_d      = in_elem;
                        pend_full_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Index mux written as a compare chain so the index width never has to match the array depth.
    always_comb begin
        out_data_c = '0;
        for (int k = 0; k < NEURON_NUM; k++) begin
            if ((state_q == SEND) && (index_q == CNT_WIDTH'(k))) begin
                out_data_c = active_q[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= '0;
            ovf_q   <= '0;
            for (int k = 0; k < NEURON_NUM; k++) begin
                active_q[k] <= '0;
            end
`ifdef LAYER_SER_PINGPONG_EN
            for (int k = 0; k < NEURON_NUM; k++) begin
                pend_q[k] <= '0;
            end
            pend_full_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            ovf_q    <= ovf_d;
            active_q <= active_d;
`ifdef LAYER_SER_PINGPONG_EN
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_last  = (state_q == SEND) && (index_q == LAST_IDX);
    assign bus.out_index = index_q;
    assign bus.out_data  = out_data_c;
    assign busy          = (state_q == SEND);
    assign ovf_cnt       = ovf_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Self-checking bench for layer_serializer (NEURON_NUM=4 main instance, NEURON_NUM=1 side instance).
module tb_layer_serializer;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy, busy1;
    logic [7:0] ovf_cnt, ovf_cnt1;

    int checks = 0;
    int failures = 0;

    layer_ser_if #(.NEURON_NUM(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
    layer_ser_if #(.NEURON_NUM(1), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus1 ();

    layer_serializer #(.NEURON_NUM(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .ovf_cnt(ovf_cnt)
    );

    layer_serializer #(.NEURON_NUM(1), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .ovf_cnt(ovf_cnt1)
    );

    always #5 clk = ~clk;

`ifdef LAYER_SER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    // Reference model: remaining beats of the vector being sent, plus an optional waiting vector.
    logic [7:0]  exp_data_q[$];
    int          exp_idx_q[$];
    bit          pend_v;
    logic [31:0] pend_vec;
    int          exp_ovf;

    function automatic bit m_in_ready();
        return PP ? !pend_v : (exp_data_q.size() == 0);
    endfunction

    task automatic m_reset();
        exp_data_q.delete();
        exp_idx_q.delete();
        pend_v  = 1'b0;
        exp_ovf = 0;
    endtask

    task automatic push_vec(input logic [31:0] v);
        for (int k = 0; k < N; k++) begin
            exp_data_q.push_back(v[k*8 +: 8]);
            exp_idx_q.push_back(k);
        end
    endtask

    // Drive one cycle of inputs, advance one clock, update the model; returns at posedge+1.
    task automatic cycle(input bit v, input logic [31:0] d, input bit r);
        bit rdy, acc, hs;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        rdy = m_in_ready();
        acc = v && rdy;
        hs  = (exp_data_q.size() > 0) && r;
        if (v && !rdy && exp_ovf < 255) exp_ovf++;
        @(posedge clk);
        if (hs) begin
            void'(exp_data_q.pop_front());
            void'(exp_idx_q.pop_front());
        end
        if (PP && exp_data_q.size() == 0 && pend_v) begin
            push_vec(pend_vec);
            pend_v = 1'b0;
        end
        if (acc) begin
            if (exp_data_q.size() == 0) push_vec(d);
            else begin
                pend_vec = d;
                pend_v   = 1'b1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%0b exp=0", bus.out_last); end
        checks++; if (bus.out_index !== 16'd0) begin failures++; $display("FAIL reset_out_index got=%0d exp=0", bus.out_index); end
        checks++; if (bus.out_data !== 8'd0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (ovf_cnt !== 8'd0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", ovf_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [7:0] e;
        cycle(1'b1, 32'h44332211, 1'b1);
        for (int i = 0; i < N; i++) begin
            e = 8'(8'h11 * (i + 1));
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid beat=%0d got=%0b exp=1", i, bus.out_valid); end
            checks++; if (bus.out_data !== e) begin failures++; $display("FAIL basic_data beat=%0d got=%0h exp=%0h", i, bus.out_data, e); end
            checks++; if (bus.out_index !== 16'(i)) begin failures++; $display("FAIL basic_index beat=%0d got=%0d exp=%0d", i, bus.out_index, i); end
            checks++; if (bus.out_last !== (i == N-1)) begin failures++; $display("FAIL basic_last beat=%0d got=%0b exp=%0b", i, bus.out_last, (i == N-1)); end
            $display("basic beat %0d data=%0h idx=%0d last=%0b", i, bus.out_data, bus.out_index, bus.out_last);
            cycle(1'b0, 32'h0, 1'b1);
        end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_end_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_end_ready got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_stall();
        cycle(1'b1, 32'h44332211, 1'b1);
        checks++; if (bus.out_data !== 8'h11) begin failures++; $display("FAIL stall_first got=%0h exp=11", bus.out_data); end
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        for (int s = 0; s < 4; s++) begin
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid s=%0d got=%0b exp=1", s, bus.out_valid); end
            checks++; if (bus.out_data !== 8'h33) begin failures++; $display("FAIL stall_data s=%0d got=%0h exp=33", s, bus.out_data); end
            checks++; if (bus.out_index !== 16'd2) begin failures++; $display("FAIL stall_index s=%0d got=%0d exp=2", s, bus.out_index); end
            $display("stall cycle %0d data=%0h idx=%0d", s, bus.out_data, bus.out_index);
            if (s < 3) cycle(1'b0, 32'h0, 1'b0);
        end
        cycle(1'b0, 32'h0, 1'b1);
        checks++; if (bus.out_data !== 8'h44 || bus.out_last !== 1'b1) begin failures++; $display("FAIL stall_resume got=%0h/%0b exp=44/1", bus.out_data, bus.out_last); end
        cycle(1'b0, 32'h0, 1'b1);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_end_valid got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_ovf();
        cycle(1'b1, 32'h44332211, 1'b0);
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, $urandom, 1'b0);
            checks++; if (bus.out_data !== exp_data_q[0] || bus.out_valid !== 1'b1) begin failures++; $display("FAIL ovf_hold i=%0d got=%0h exp=%0h", i, bus.out_data, exp_data_q[0]); end
            checks++; if (ovf_cnt !== 8'(exp_ovf)) begin failures++; $display("FAIL ovf_cnt i=%0d got=%0d exp=%0d", i, ovf_cnt, exp_ovf); end
        end
        $display("ovf after hold=%0d", ovf_cnt);
        checks++; if (ovf_cnt !== 8'd255) begin failures++; $display("FAIL ovf_saturate got=%0d exp=255", ovf_cnt); end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            checks++; if (bus.out_valid !== (exp_data_q.size() > 0)) begin failures++; $display("FAIL ovf_drain_valid i=%0d got=%0b", i, bus.out_valid); end
            if (exp_data_q.size() > 0) begin
                checks++; if (bus.out_data !== exp_data_q[0]) begin failures++; $display("FAIL ovf_drain_data i=%0d got=%0h exp=%0h", i, bus.out_data, exp_data_q[0]); end
            end
        end
        checks++; if (ovf_cnt !== 8'd255) begin failures++; $display("FAIL ovf_stays got=%0d exp=255", ovf_cnt); end
    endtask

    task automatic test_random();
        bit exp_v, exp_last;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) != 0);
            exp_v    = exp_data_q.size() > 0;
            exp_last = exp_v && (exp_idx_q[0] == N-1);
            checks++; if (bus.out_valid !== exp_v) begin failures++; $display("FAIL rnd_valid i=%0d got=%0b exp=%0b", i, bus.out_valid, exp_v); end
            checks++; if (bus.out_last !== exp_last) begin failures++; $display("FAIL rnd_last i=%0d got=%0b exp=%0b", i, bus.out_last, exp_last); end
            checks++; if (busy !== exp_v) begin failures++; $display("FAIL rnd_busy i=%0d got=%0b exp=%0b", i, busy, exp_v); end
            checks++; if (bus.in_ready !== m_in_ready()) begin failures++; $display("FAIL rnd_in_ready i=%0d got=%0b exp=%0b", i, bus.in_ready, m_in_ready()); end
            checks++; if (ovf_cnt !== 8'(exp_ovf)) begin failures++; $display("FAIL rnd_ovf i=%0d got=%0d exp=%0d", i, ovf_cnt, exp_ovf); end
            if (exp_v) begin
                checks++; if (bus.out_data !== exp_data_q[0]) begin failures++; $display("FAIL rnd_data i=%0d got=%0h exp=%0h", i, bus.out_data, exp_data_q[0]); end
                checks++; if (bus.out_index !== 16'(exp_idx_q[0])) begin failures++; $display("FAIL rnd_index i=%0d got=%0d exp=%0d", i, bus.out_index, exp_idx_q[0]); end
            end
        end
        $display("random done ovf=%0d", ovf_cnt);
    endtask

    task automatic test_back_to_back();
        do_reset();
`ifdef LAYER_SER_PINGPONG_EN
        begin
            logic [7:0] b2b [8];
            b2b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
            cycle(1'b1, 32'h44332211, 1'b1);
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== b2b[0]) begin failures++; $display("FAIL b2b_beat0 got=%0h exp=%0h", bus.out_data, b2b[0]); end
            cycle(1'b1, 32'h88776655, 1'b1);
            for (int i = 1; i < 8; i++) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== b2b[i]) begin failures++; $display("FAIL b2b_beat i=%0d got=%0h/%0b exp=%0h/1", i, bus.out_data, bus.out_valid, b2b[i]); end
                $display("b2b beat %0d data=%0h", i, bus.out_data);
                cycle(1'b0, 32'h0, 1'b1);
            end
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%0b exp=0", bus.out_valid); end
            checks++; if (ovf_cnt !== 8'd0) begin failures++; $display("FAIL b2b_ovf got=%0d exp=0", ovf_cnt); end
        end
`else
        begin
            bit sent = 1'b0;
            bit rdy;
            cycle(1'b1, 32'h44332211, 1'b1);
            for (int i = 0; i < 12; i++) begin
                checks++; if (bus.out_valid !== (exp_data_q.size() > 0)) begin failures++; $display("FAIL b2b_valid i=%0d got=%0b", i, bus.out_valid); end
                if (exp_data_q.size() > 0) begin
                    checks++; if (bus.out_data !== exp_data_q[0]) begin failures++; $display("FAIL b2b_data i=%0d got=%0h exp=%0h", i, bus.out_data, exp_data_q[0]); end
                end
                $display("b2b cycle %0d valid=%0b data=%0h", i, bus.out_valid, bus.out_data);
                rdy = m_in_ready();
                cycle(!sent, 32'h88776655, 1'b1);
                if (rdy) sent = 1'b1;
            end
            checks++; if (ovf_cnt !== 8'(exp_ovf)) begin failures++; $display("FAIL b2b_ovf got=%0d exp=%0d", ovf_cnt, exp_ovf); end
        end
`endif
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 32'h44332211, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'd0) begin failures++; $display("FAIL midrst_data got=%0h exp=0", bus.out_data); end
        checks++; if (bus.out_index !== 16'd0 || bus.out_last !== 1'b0) begin failures++; $display("FAIL midrst_idx_last got=%0d/%0b exp=0/0", bus.out_index, bus.out_last); end
        checks++; if (busy !== 1'b0 || ovf_cnt !== 8'd0) begin failures++; $display("FAIL midrst_busy_ovf got=%0b/%0d exp=0/0", busy, ovf_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_resume i=%0d valid=%0b data=%0h exp no beat", i, bus.out_valid, bus.out_data); end
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready i=%0d got=%0b exp=1", i, bus.in_ready); end
            cycle(1'b0, 32'h0, 1'b1);
        end
        $display("reset_mid done");
    endtask

    task automatic test_single();
        bus.in_valid   = 1'b0;
        bus1.in_data   = 8'h5A;
        bus1.in_valid  = 1'b1;
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        checks++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== 8'h5A) begin failures++; $display("FAIL single_beat got=%0h/%0b exp=5a/1", bus1.out_data, bus1.out_valid); end
        checks++; if (bus1.out_last !== 1'b1 || bus1.out_index !== 16'd0) begin failures++; $display("FAIL single_last got=%0b/%0d exp=1/0", bus1.out_last, bus1.out_index); end
        $display("single beat data=%0h last=%0b", bus1.out_data, bus1.out_last);
        @(posedge clk);
        #1;
        checks++; if (bus1.out_valid !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL single_idle got=%0b/%0b exp=0/0", bus1.out_valid, busy1); end
        checks++; if (bus1.in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%0b exp=1", bus1.in_ready); end
    endtask

    initial begin
        bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
        m_reset();
        test_reset();
        test_basic();
        test_stall();
        test_ovf();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_single();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 SHALL have parameter NEURON_NUM, default 30: elements per input vector, legal range >= 1.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: bits per element.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of out_index, with 2^CNT_WIDTH > NEURON_NUM.
REQ-004 SHALL have one clock and an asynchronous active-low reset; SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_data  input  NEURON_NUM*DATA_WIDTH  packed layer vector; element k = bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  vector accepted when in_valid && in_ready.
REQ-009 SHALL have port out_data  output  DATA_WIDTH  current element.
REQ-010 SHALL have port out_valid  output  1  out_data is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the beat when out_valid && out_ready.
REQ-012 SHALL have port out_last  output  1  current beat is element NEURON_NUM-1.
REQ-013 SHALL have port out_index  output  CNT_WIDTH  index of current element.
REQ-014 SHALL have port busy  output  1  high whenever state is SEND.
REQ-015 SHALL have port ovf_cnt  output  8  saturating count of cycles with in_valid && !in_ready.

Function
REQ-016 SHALL implement two states, IDLE and SEND; in IDLE, in_ready=1 and out_valid=0.
REQ-017 SHALL, on an IDLE input handshake, register all of in_data into the active buffer, set index=0 and enter SEND; the first out_valid SHALL be asserted the following cycle (latency 1).
REQ-018 SHALL, in SEND, hold out_valid=1 with out_data = active element[index]; out_data, out_index and out_last SHALL stay stable while out_ready=0.
REQ-019 SHALL advance index by 1 on each output handshake, emitting element 0 first and element NEURON_NUM-1 last, exactly NEURON_NUM beats per vector with no extra or missing beat.
REQ-020 SHALL assert out_last only when out_valid=1 and index==NEURON_NUM-1; with NEURON_NUM=1 every beat SHALL be last.
REQ-021 SHALL, on the last-beat handshake with no further vector available, return to IDLE, leaving out_valid=0 in the next cycle.
REQ-022 SHALL increment ovf_cnt on every cycle with in_valid=1 and in_ready=0, saturating at 255 without wrapping; the dropped vector SHALL NOT affect the output.

Reset
REQ-023 SHALL, while rst_n=0 (asynchronous), force state=IDLE, index=0, out_valid=0, out_last=0, out_index=0, out_data=0, busy=0, ovf_cnt=0 and any pending buffer empty; in_ready SHALL be 1 after reset.
REQ-024 SHALL, when reset asserts mid-vector, abandon the vector; after release, no remaining beats of that vector SHALL be emitted.

Configuration
REQ-025 SHALL provide a double-buffer feature compiled in only when macro LAYER_SER_PINGPONG_EN is defined.
REQ-026 SHALL, without LAYER_SER_PINGPONG_EN, hold in_ready=0 throughout SEND, and SHALL spend one IDLE cycle between consecutive vectors.
REQ-027 SHALL, with LAYER_SER_PINGPONG_EN, add one pending buffer: in_ready = pending empty; a vector accepted during SEND fills the pending buffer; on the last-beat handshake a full pending buffer SHALL load into the active buffer with index=0 and state SEND, with no bubble.
REQ-028 SHALL, with LAYER_SER_PINGPONG_EN, when an input handshake coincides with a last-beat handshake and the pending buffer is empty, load the input directly into the active buffer and remain in SEND with no bubble.

Verification (NEURON_NUM=4, DATA_WIDTH=8 unless stated)
REQ-029 SHALL cover: in_data=0x44332211 pulsed for 1 cycle with out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after capture; out_last only on 0x44; out_index 0..3.
REQ-030 SHALL cover: out_ready=0 for 3 cycles while index=2 -> out_data held at 0x33, out_index=2, out_valid=1; the sequence resumes with 0x44.
REQ-031 SHALL cover: macro undefined, in_valid held high for 300 cycles during SEND -> ovf_cnt reaches 255 and stays 255; output stream unchanged.
REQ-032 SHALL cover: macro defined, vectors 0x44332211 and 0x88776655 back-to-back -> 8 contiguous beats 0x11..0x88 with no out_valid gap; ovf_cnt=0.
REQ-033 SHALL cover: rst_n pulsed low after beat 0x22 -> all outputs 0 immediately; after release, in_ready=1 and no 0x33 or 0x44 is emitted.
REQ-034 SHALL cover: NEURON_NUM=1, in_data=0x5A -> a single beat 0x5A with out_last=1, then IDLE.
